// File: rtl/famicom_pad_serializer.sv
// ============================================================================
// Module   : famicom_pad_serializer
// Brief    : Multi-port NES/SNES serial pad emulator driven by the core's
//            latch/pulse strobes. Optional turbo: FAMICOM_PAD_TURBO_EN.
// Revision : 1.0 - initial multi-port release
// ============================================================================
`default_nettype none

module famicom_pad_serializer #(
    parameter int   NUM_PADS    = 2,
    parameter int   BITS        = 8,
    parameter logic FILL        = 1'b1,
    parameter int   SYNC_STAGES = 2,
    parameter int   TURBO_DIV   = 4
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [NUM_PADS*BITS-1:0] pad_state,
`ifdef FAMICOM_PAD_TURBO_EN
    input  logic [NUM_PADS*BITS-1:0] turbo_mask,
`endif
    input  logic                     latch,
    input  logic [NUM_PADS-1:0]      pulse,
    output logic [NUM_PADS-1:0]      data_n,
    output logic [NUM_PADS-1:0]      read_done,
    output logic [NUM_PADS*8-1:0]    shift_count
);

    localparam logic [7:0] c_bits = 8'(BITS);

    if (BITS < 1 || BITS > 255) begin : g_bits_check
        $error("famicom_pad_serializer: BITS must be in 1..255");
    end
    if (SYNC_STAGES < 2) begin : g_sync_check
        $error("famicom_pad_serializer: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0]   r_latch_sync;
    logic                     w_latch_s;
    logic [NUM_PADS*BITS-1:0] w_btn;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_latch_sync <= '0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch};
        end
    end

    assign w_latch_s = r_latch_sync[SYNC_STAGES-1];

`ifdef FAMICOM_PAD_TURBO_EN
    localparam int             c_tw   = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [c_tw-1:0] c_tmax = c_tw'(TURBO_DIV - 1);

    logic            r_latch_dly;
    logic [c_tw-1:0] r_tcnt;
    logic            r_phase;
    logic            r_load_phase;
    logic            w_latch_rise;
    logic            w_phase;

    assign w_latch_rise = w_latch_s & ~r_latch_dly;
    // The phase seen at the latch edge is held for the whole read, so a wrap
    // on this very edge only affects the next latch.
    assign w_phase = w_latch_rise ? r_phase : r_load_phase;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_latch_dly  <= 1'b0;
            r_tcnt       <= '0;
            r_phase      <= 1'b0;
            r_load_phase <= 1'b0;
        end else begin
            r_latch_dly <= w_latch_s;
            if (w_latch_rise) begin
                r_load_phase <= r_phase;
                if (r_tcnt == c_tmax) begin
                    r_tcnt  <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end
        end
    end

    assign w_btn = pad_state & ~(turbo_mask & {(NUM_PADS*BITS){w_phase}});
`else
    assign w_btn = pad_state;
`endif

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [SYNC_STAGES-1:0] r_psync;
        logic                   r_pdly;
        logic                   w_prise;
        logic [BITS-1:0]        r_shreg;
        logic [BITS-1:0]        w_shifted;
        logic [7:0]             r_cnt;
        logic                   r_done;
        logic                   r_data;

        assign w_prise = r_psync[SYNC_STAGES-1] & ~r_pdly;

        if (BITS > 1) begin : g_wide
            assign w_shifted = {FILL, r_shreg[BITS-1:1]};
        end else begin : g_narrow
            assign w_shifted = FILL;
        end

        // Latch is level-sensitive and overrides any pulse edge in the same cycle.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_psync <= '0;
                r_pdly  <= 1'b0;
                r_shreg <= {BITS{FILL}};
                r_cnt   <= 8'd0;
                r_done  <= 1'b0;
                r_data  <= FILL;
            end else begin
                r_psync <= {r_psync[SYNC_STAGES-2:0], pulse[p]};
                r_pdly  <= r_psync[SYNC_STAGES-1];
                r_done  <= 1'b0;
                r_data  <= r_shreg[0];
                if (w_latch_s) begin
                    r_shreg <= ~w_btn[p*BITS +: BITS];
                    r_cnt   <= 8'd0;
                end else if (w_prise) begin
                    r_shreg <= w_shifted;
                    if (r_cnt != c_bits) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_bits - 8'd1) begin
                            r_done <= 1'b1;
                        end
                    end
                end
            end
        end

        assign data_n[p]           = r_data;
        assign read_done[p]        = r_done;
        assign shift_count[p*8 +: 8] = r_cnt;
    end

endmodule

`default_nettype wire
